// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES encodings: FSM states, round count, forward S-box
package aes_pkg;

  localparam logic [3:0] AES_NR = 4'd14;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SUBBYTES,
    SHIFTROWS,
    MIXCOLUMNS,
    ADDROUNDKEY,
    FINALKEY,
    DONE
  } aes_state_e;

  // Entry 0x00 occupies the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[8 * (255 - int'(b)) +: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127 - 8 * i -: 8] = sbox(s[127 - 8 * i -: 8]);
    return r;
  endfunction

  // Column-major layout: byte index = 4*column + row.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127 - 8 * (4 * c + w) -: 8] = s[127 - 8 * (4 * ((c + w) % 4) + w) -: 8];
    return r;
  endfunction

endpackage

// File: rtl/aes_encrypt_if.sv
// rtl/aes_encrypt_if.sv - block/key/result bundle between key schedule host and aes_encrypt
interface aes_encrypt_if;
  logic         encrypt_en;
  logic [127:0] round_key;
  logic [127:0] word;
  logic [127:0] encrypted_word;
  logic [3:0]   round;
  logic         AES_en_done;

  modport master (
    output encrypt_en, round_key, word,
    input  encrypted_word, round, AES_en_done
  );

  modport slave (
    input  encrypt_en, round_key, word,
    output encrypted_word, round, AES_en_done
  );
endinterface

// File: rtl/aes_mix_columns.sv
// rtl/aes_mix_columns.sv - combinational forward MixColumns over the full 128-bit state
module aes_mix_columns (
  input  logic [127:0] din,
  output logic [127:0] dout
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  always_comb begin
    dout = '0;
    for (int c = 0; c < 4; c++) dout[127 - 32 * c -: 32] = mix_col(din[127 - 32 * c -: 32]);
  end

endmodule

// File: rtl/aes_encrypt.sv
// rtl/aes_encrypt.sv - iterative AES-256 encrypt, one transform step per cycle
// Optional: AES_ENC_RESTART_EN lets encrypt_en restart from DONE.
module aes_encrypt
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         srst_n,
  aes_encrypt_if.slave bus
);

  aes_state_e   state_q, state_d;
  logic [127:0] blk_q, blk_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;
  logic [127:0] mixed;

  aes_mix_columns u_mix (
    .din  (blk_q),
    .dout (mixed)
  );

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    round_d = round_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        if (bus.encrypt_en) begin
          state_d = INIT;
          round_d = 4'd0;
        end
      end
      INIT: begin
        blk_d   = bus.word ^ bus.round_key;
        round_d = 4'd1;
        state_d = SUBBYTES;
      end
      SUBBYTES: begin
        blk_d   = sub_bytes(blk_q);
        state_d = SHIFTROWS;
      end
      SHIFTROWS: begin
        blk_d   = shift_rows(blk_q);
        state_d = (round_q == AES_NR) ? FINALKEY : MIXCOLUMNS;
      end
      MIXCOLUMNS: begin
        blk_d   = mixed;
        state_d = ADDROUNDKEY;
      end
      // Only reached for rounds below AES_NR, so round cannot pass 14.
      ADDROUNDKEY: begin
        blk_d   = blk_q ^ bus.round_key;
        round_d = round_q + 4'd1;
        state_d = SUBBYTES;
      end
      FINALKEY: begin
        blk_d   = blk_q ^ bus.round_key;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
`ifdef AES_ENC_RESTART_EN
        if (bus.encrypt_en) begin
          state_d = INIT;
          round_d = 4'd0;
          done_d  = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q <= IDLE;
      blk_q   <= '0;
      round_q <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign bus.encrypted_word = blk_q;
  assign bus.round          = round_q;
  assign bus.AES_en_done    = done_q;

endmodule

// File: tb/tb_aes_encrypt.sv
// tb/tb_aes_encrypt.sv - directed FIPS-197 vectors, round trace, reset and restart checks
module tb_aes_encrypt;

  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C3  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT_Z   = 128'hdc95c078a2408989ad48a21492842087;

  logic clk;
  logic srst_n;
  logic [127:0] rk [15];
  int checks;
  int failures;

  aes_encrypt_if bus ();

  aes_encrypt dut (
    .clk    (clk),
    .srst_n (srst_n),
    .bus    (bus)
  );

  assign bus.round_key = rk[bus.round];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Reference S-box from its definition: GF(2^8) inverse then affine map.
  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] t, s;
    for (int y = 1; y < 256; y++)
      if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    t = inv;
    s = inv;
    for (int i = 0; i < 4; i++) begin
      t = {t[6:0], t[7]};
      s ^= t;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {ref_sbox(w[31:24]), ref_sbox(w[23:16]), ref_sbox(w[15:8]), ref_sbox(w[7:0])};
  endfunction

  task automatic expand_key(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i - 1];
      if (i % 8 == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i - 8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  function automatic logic [3:0] exp_round(input int n);
    return (n == 0) ? 4'd0 : 4'(1 + (n - 1) / 4);
  endfunction

  task automatic do_reset();
    srst_n = 1'b0;
    bus.encrypt_en = 1'b0;
    @(posedge clk);
    #1;
    srst_n = 1'b1;
  endtask

  task automatic run(input string tag, input logic [127:0] exp_ct, input bit hold);
    int n = 0;
    int trace_err = 0;
    bit seen = 1'b0;
    bus.encrypt_en = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.encrypt_en = 1'b0;
    check({tag, "_init_round"}, 128'(bus.round), 128'(0));
    check({tag, "_init_done"}, 128'(bus.AES_en_done), 128'(0));
    while (n < 70 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (n <= 56 && bus.round !== exp_round(n)) trace_err++;
      seen = bus.AES_en_done;
    end
    bus.encrypt_en = 1'b0;
    check({tag, "_latency"}, 128'(n), 128'(56));
    check({tag, "_round_trace_errs"}, 128'(trace_err), 128'(0));
    check({tag, "_final_round"}, 128'(bus.round), 128'(14));
    check({tag, "_ct"}, bus.encrypted_word, exp_ct);
  endtask

  initial begin
    bit hit;
    checks = 0;
    failures = 0;
    clk = 1'b0;
    srst_n = 1'b0;
    bus.encrypt_en = 1'b0;
    bus.word = '0;
    expand_key(KEY_C3);
    repeat (2) @(posedge clk);
    #1;
    check("rst_round", 128'(bus.round), 128'(0));
    check("rst_done", 128'(bus.AES_en_done), 128'(0));
    check("rst_ct", bus.encrypted_word, 128'(0));
    srst_n = 1'b1;

    bus.word = PT_C3;
    run("c3", CT_C3, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("c3_sticky_done", 128'(bus.AES_en_done), 128'(1));
    check("c3_sticky_ct", bus.encrypted_word, CT_C3);

`ifdef AES_ENC_RESTART_EN
    run("restart", CT_C3, 1'b0);
`else
    bus.encrypt_en = 1'b1;
    @(posedge clk);
    #1;
    bus.encrypt_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("norestart_done", 128'(bus.AES_en_done), 128'(1));
    check("norestart_round", 128'(bus.round), 128'(14));
    check("norestart_ct", bus.encrypted_word, CT_C3);
`endif

    do_reset();
    bus.encrypt_en = 1'b1;
    @(posedge clk);
    #1;
    bus.encrypt_en = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(posedge clk);
      #1;
      hit = (bus.round == 4'd7);
    end
    check("midrst_reached_r7", 128'(hit), 128'(1));
    srst_n = 1'b0;
    @(posedge clk);
    #1;
    srst_n = 1'b1;
    check("midrst_round", 128'(bus.round), 128'(0));
    check("midrst_done", 128'(bus.AES_en_done), 128'(0));
    check("midrst_ct", bus.encrypted_word, 128'(0));
    run("c3_rerun", CT_C3, 1'b0);

    srst_n = 1'b0;
    bus.encrypt_en = 1'b1;
    @(posedge clk);
    #1;
    srst_n = 1'b1;
    bus.encrypt_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_en_ct", bus.encrypted_word, 128'(0));
    check("rst_en_round", 128'(bus.round), 128'(0));
    check("rst_en_done", 128'(bus.AES_en_done), 128'(0));

    expand_key(256'h0);
    bus.word = '0;
    run("zero", CT_Z, 1'b0);

    do_reset();
    expand_key(KEY_C3);
    bus.word = PT_C3;
    run("held", CT_C3, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("held_done", 128'(bus.AES_en_done), 128'(1));
    check("held_ct", bus.encrypted_word, CT_C3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_encrypt.md
AES_ENCRYPT -- requirements
Module: aes_encrypt

Interface
REQ-001 The module SHALL have no parameters; the round count is fixed at 14 (AES-256) by the package constant AES_NR.
REQ-002 clk  input  1  clock; all state SHALL update on rising edge only.
REQ-003 srst_n  input  1  reset, synchronous, active-low.
REQ-004 encrypt_en  input  1  start request, sampled only in IDLE (and DONE when AES_ENC_RESTART_EN is defined).
REQ-005 round_key  input  128  key for the round indicated by round, supplied combinationally by the external key schedule.
REQ-006 word  input  128  plaintext, sampled only in INIT.
REQ-007 encrypted_word  output  128  ciphertext, equal to the internal state register at all times.
REQ-008 round  output  4  index of the round key the block currently requires (0..14).
REQ-009 AES_en_done  output  1  registered completion flag.

Function
REQ-010 The FSM SHALL have states IDLE, INIT, SUBBYTES, SHIFTROWS, MIXCOLUMNS, ADDROUNDKEY, FINALKEY and DONE, one state per cycle.
REQ-011 IDLE with encrypt_en=1 SHALL go to INIT with round<=0; otherwise it stays in IDLE.
REQ-012 INIT SHALL load state<=word^round_key (round 0), set round<=1 and go to SUBBYTES.
REQ-013 SUBBYTES SHALL apply the forward S-box to all 16 bytes and go to SHIFTROWS.
REQ-014 SHIFTROWS SHALL rotate row r left by r bytes (column-major, byte 0 = bits 127:120). It goes to FINALKEY if round==14, else to MIXCOLUMNS.
REQ-015 MIXCOLUMNS SHALL apply forward MixColumns ({02,03,01,01} circulant over GF(2^8), polynomial 0x11B) and go to ADDROUNDKEY.
REQ-016 ADDROUNDKEY SHALL XOR round_key into the state, set round<=round+1 and go to SUBBYTES.
REQ-017 FINALKEY SHALL XOR round_key into the state, set AES_en_done<=1 and go to DONE.
REQ-018 DONE SHALL hold state, round=14 and AES_en_done=1.
REQ-019 Latency SHALL be 56 clock edges from the edge sampling encrypt_en in IDLE to the edge setting AES_en_done; encrypted_word SHALL be valid on that same edge.
REQ-020 round_key SHALL be consumed only in INIT, ADDROUNDKEY and FINALKEY; its value in all other states is don't-care.
REQ-021 encrypt_en SHALL be ignored in all states except IDLE (and DONE per REQ-025).
REQ-022 round SHALL never exceed 14 and SHALL never wrap.

Reset
REQ-023 srst_n=0 at any cycle, including mid-operation, SHALL force state=IDLE, round=0, AES_en_done=0 and the state register (encrypted_word) to 0 on the next edge.
REQ-024 srst_n=0 together with encrypt_en=1 SHALL result in reset only; no start occurs.

Configuration
REQ-025 Macro AES_ENC_RESTART_EN:
- When defined, encrypt_en=1 in DONE SHALL go to INIT with round<=0 and AES_en_done<=0.
- When undefined, DONE SHALL be sticky until srst_n.

Structure
REQ-026 Package aes_pkg SHALL hold the FSM state encoding typedef, AES_NR=14, and the forward S-box constant table shared with the decrypt path.
REQ-027 Forward MixColumns SHALL be a combinational sub-module aes_mix_columns (128-bit in, 128-bit out), instantiated once.

Verification
REQ-028 FIPS-197 C.3 vector: word=00112233445566778899aabbccddeeff, key=000102...1e1f, reference key schedule -> encrypted_word=8ea2b7ca516745bfeafc49904b496089, AES_en_done rising 56 edges after start.
REQ-029 All-zero word and key -> encrypted_word=dc95c078a2408989ad48a21492842087.
REQ-030 Round trace during REQ-028 -> round=0 in INIT, incrementing by 1 per ADDROUNDKEY, and round=14 in SHIFTROWS, FINALKEY and DONE.
REQ-031 srst_n pulsed low while round=7 -> round=0, AES_en_done=0, encrypted_word=0 next cycle; a rerun of REQ-028 then passes.
REQ-032 encrypt_en held at 1 throughout a run -> single encryption, result unchanged. A pulse in DONE restarts (AES_en_done drops, new result after 56 edges) only with AES_ENC_RESTART_EN; without it, no change.
